// File: rtl/quad_corner_ctrl.sv
// quad_corner_ctrl: holds the four quadrilateral corners (x1..y4) and moves the
// selected one per frame strobe, with per-axis clamping to the screen and
// hold-to-accelerate stepping. All corner updates happen in frame_stb cycles.
module quad_corner_ctrl #(
   parameter int H_MAX       = 640,
   parameter int V_MAX       = 480,
   parameter int SLOW_STEP   = 1,
   parameter int FAST_STEP   = 8,
   parameter int HOLD_FRAMES = 30
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       frame_stb,
   input  logic [1:0] sel,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       restore,
   output logic [9:0] x1,
   output logic [9:0] x2,
   output logic [9:0] x3,
   output logic [9:0] x4,
   output logic [8:0] y1,
   output logic [8:0] y2,
   output logic [8:0] y3,
   output logic [8:0] y4,
   output logic       coords_upd,
   output logic       accel
);

   typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;

   localparam int CNT_W = $clog2(HOLD_FRAMES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_FRAMES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   localparam logic signed [11:0] X_SLOW = 12'(SLOW_STEP);
   localparam logic signed [11:0] X_FAST = 12'(FAST_STEP);
   localparam logic signed [10:0] Y_SLOW = 11'(SLOW_STEP);
   localparam logic signed [10:0] Y_FAST = 11'(FAST_STEP);
   localparam logic signed [11:0] X_LIM  = 12'(H_MAX - 1);
   localparam logic signed [10:0] Y_LIM  = 11'(V_MAX - 1);

   // Corners are ordered around the perimeter: index 0..3 = corner 1..4.
   localparam logic [3:0][9:0] X_DEF = {10'd0, 10'(H_MAX - 1), 10'(H_MAX - 1), 10'd0};
   localparam logic [3:0][8:0] Y_DEF = {9'(V_MAX - 1), 9'(V_MAX - 1), 9'd0, 9'd0};

   state_t state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [1:0] last_sel;
   logic [3:0][9:0] xs, xs_nxt;
   logic [3:0][8:0] ys, ys_nxt;
   logic moving;
   logic use_fast;
   logic signed [11:0] dx, sum_x;
   logic signed [10:0] dy, sum_y;
   logic [9:0] clamp_x;
   logic [8:0] clamp_y;

   // Acceleration FSM: counts consecutive moving strobes on the same corner.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      use_fast  = 1'b0;
      moving    = (btn_left ^ btn_right) | (btn_up ^ btn_down);
      if (restore || !moving) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else if (state == IDLE || sel != last_sel) begin
         cnt_nxt   = CNT_ONE;
         state_nxt = (CNT_ONE >= CNT_MAX) ? FAST : SLOW;
      end else if (state == SLOW) begin
         if (cnt < CNT_MAX) cnt_nxt = cnt + 1'b1;
         if (cnt_nxt >= CNT_MAX) state_nxt = FAST;
      end else begin
         use_fast  = 1'b1;
         state_nxt = FAST;
         if (cnt < CNT_MAX) cnt_nxt = cnt + 1'b1;
      end
   end

   // Move the selected corner by the resolved step and clamp each axis.
   always_comb begin
      dx = 12'sd0;
      dy = 11'sd0;
      if (btn_right && !btn_left) dx = use_fast ? X_FAST : X_SLOW;
      else if (btn_left && !btn_right) dx = use_fast ? -X_FAST : -X_SLOW;
      if (btn_down && !btn_up) dy = use_fast ? Y_FAST : Y_SLOW;
      else if (btn_up && !btn_down) dy = use_fast ? -Y_FAST : -Y_SLOW;

      sum_x = $signed({2'b00, xs[sel]}) + dx;
      sum_y = $signed({2'b00, ys[sel]}) + dy;

      if (sum_x < 12'sd0) clamp_x = '0;
      else if (sum_x > X_LIM) clamp_x = X_LIM[9:0];
      else clamp_x = sum_x[9:0];

      if (sum_y < 11'sd0) clamp_y = '0;
      else if (sum_y > Y_LIM) clamp_y = Y_LIM[8:0];
      else clamp_y = sum_y[8:0];

      xs_nxt = xs;
      ys_nxt = ys;
      if (restore) begin
         xs_nxt = X_DEF;
         ys_nxt = Y_DEF;
      end else begin
         xs_nxt[sel] = clamp_x;
         ys_nxt[sel] = clamp_y;
      end
   end

   // FSM state, hold counter and last-strobe corner select advance on strobes only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         last_sel <= 2'd0;
      end else if (frame_stb) begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         last_sel <= sel;
      end
   end

   // Corner registers commit on strobes; coords_upd flags any real change.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         xs         <= X_DEF;
         ys         <= Y_DEF;
         coords_upd <= 1'b0;
      end else begin
         coords_upd <= frame_stb && ((xs_nxt != xs) || (ys_nxt != ys));
         if (frame_stb) begin
            xs <= xs_nxt;
            ys <= ys_nxt;
         end
      end
   end

   assign accel = (state == FAST);
   assign x1 = xs[0];
   assign x2 = xs[1];
   assign x3 = xs[2];
   assign x4 = xs[3];
   assign y1 = ys[0];
   assign y2 = ys[1];
   assign y3 = ys[2];
   assign y4 = ys[3];

endmodule

// File: doc/quad_corner_ctrl.md
Name: quad_corner_ctrl

Overview:
- Upstream stage of the pixels-kept calculator. Owns the four quadrilateral corner registers (x1..y4) that the calculator and the projective-warp datapath consume.
- A user picks one corner and nudges it with debounced direction inputs. Moves take effect only on the frame strobe, so every consumer sees a consistent quad for a whole frame.
- Per-axis saturation keeps the corners inside the 640x480 screen. Holding a direction accelerates after a programmable number of frames.

Parameters:
- H_MAX, 640, horizontal screen size; x range is 0..H_MAX-1.
- V_MAX, 480, vertical screen size; y range is 0..V_MAX-1.
- SLOW_STEP, 1, pixels moved per frame before acceleration.
- FAST_STEP, 8, pixels moved per frame after acceleration.
- HOLD_FRAMES, 30, number of consecutive moving frames before FAST_STEP applies.

Ports:
- clk  in  1  system clock (65 MHz pixel domain).
- reset_n  in  1  asynchronous, active-low reset.
- frame_stb  in  1  one-cycle pulse at the start of vertical blanking.
- sel  in  2  corner select: 0 selects (x1,y1), 1 selects (x2,y2), 2 selects (x3,y3), 3 selects (x4,y4).
- btn_up, btn_down, btn_left, btn_right  in  1 each  debounced, synchronous, level-sensitive direction inputs.
- restore  in  1  level input; request to restore the default quad.
- x1, x2, x3, x4  out  10 each  registered corner x coordinates.
- y1, y2, y3, y4  out  9 each  registered corner y coordinates.
- coords_upd  out  1  one-cycle pulse, asserted the cycle after any corner register changes.
- accel  out  1  high while FAST_STEP is in effect.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - (x1,y1)=(0,0), (x2,y2)=(H_MAX-1,0), (x3,y3)=(H_MAX-1,V_MAX-1), (x4,y4)=(0,V_MAX-1). Corners are ordered around the perimeter so the diagonals are 1-3 and 2-4.
  - coords_upd=0, accel=0, hold counter=0.
- All corner registers change only in the cycle where frame_stb=1. Between strobes the outputs are frozen regardless of any input activity.
- sel and the buttons are sampled in the frame_stb cycle only. Changing sel between strobes has no effect on the corners.
- Direction resolution at the strobe:
  - dx = +step if only btn_right is high, -step if only btn_left is high, 0 if both or neither.
  - dy = +step if only btn_down is high (y grows downward), -step if only btn_up is high, 0 if both or neither.
- Arithmetic:
  - new_x = current_x + dx, computed as 12-bit signed and clamped to [0, H_MAX-1].
  - new_y = current_y + dy, computed as 11-bit signed and clamped to [0, V_MAX-1].
  - Only the selected corner is written.
- Hold counter and acceleration FSM, states IDLE, SLOW, FAST, evaluated per strobe:
  - "Moving" means dx≠0 or dy≠0 after resolution.
  - Not moving: go to IDLE and clear the counter.
  - From IDLE, moving: go to SLOW with counter=1, and use SLOW_STEP for this strobe.
  - From SLOW, moving: counter increments. When the counter reaches HOLD_FRAMES, go to FAST starting with the next strobe.
  - FAST uses FAST_STEP and stays in FAST while moving.
  - A change of sel at a strobe returns the FSM to SLOW (counter=1) even while moving.
  - The counter saturates and never wraps.
  - accel=1 exactly while the state is FAST.
- restore=1 at a strobe takes priority over movement:
  - All four corners return to their reset values.
  - The FSM goes to IDLE.
  - coords_upd pulses if any corner changed value.
- coords_upd is a one-cycle pulse in the cycle after a strobe that changed at least one bit of x1..y4. It stays 0 when a move is fully clamped, e.g. pressing left at x=0.
- Latency: button state at a strobe appears on the outputs 1 cycle later, together with coords_upd.
- Reset asserted mid-frame forces the defaults immediately. Pending movement is discarded.
- frame_stb held high for several cycles is a protocol violation. The block still treats each high cycle as a separate strobe; this is documented, not guarded.

Test Plan:
- Release reset, no buttons, 3 strobes -> outputs (0,0),(639,0),(639,479),(0,479); coords_upd never pulses; accel=0.
- sel=0, btn_right held for 5 strobes -> x1=5, y1=0; coords_upd pulses 5 times, each 1 cycle after its strobe; other corners unchanged.
- sel=2, btn_down+btn_right held for 2 strobes -> x3=639, y3=479 (clamped); coords_upd=0 both times.
- sel=1, btn_left held for 40 strobes (HOLD_FRAMES=30) -> steps 1..30 move 1 px each, then 10 strobes of 8 px; x2=639-30-80=529; accel rises after the 30th strobe.
- sel=3, btn_up+btn_down+btn_right held for 1 strobe -> x4=1, y4=479; the opposing vertical buttons cancel.
- After moves, restore=1 with btn_right held at a strobe -> all defaults restored; coords_upd pulses once; accel=0; then reset_n pulsed low mid-frame -> defaults hold immediately and asynchronously.
